// File: rtl/shim_ads816x_adc_sequencer.sv
// rtl/shim_ads816x_adc_sequencer.sv - ADS816x channel sweep sequencer (OTF mode) in front of the SPI frame engine
module shim_ads816x_adc_sequencer #(
  parameter int          N_CH           = 8,
  parameter logic [12:0] OTF_CMD_PREFIX = 13'b1010_0000_0000_0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  output logic        tcalc_start,
  input  logic        tcalc_done,
  input  logic        tcalc_lock_viol,
  input  logic [7:0]  n_cs_high_time,
  input  logic        trig,
  input  logic [3:0]  sweep_len,
  output logic        ready,
  output logic        bad_cmd,
  output logic        xfer_start,
  output logic [15:0] xfer_cmd,
  input  logic        xfer_done,
  input  logic [15:0] xfer_data,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [15:0] sample_data,
  output logic        sweep_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_READY, S_XFER, S_GAP, S_DRAIN, S_ERROR
  } state_t;

  localparam logic [3:0] N_CH_L = 4'(N_CH);

  state_t     state;
  logic [7:0] gap_cnt;   // cycles left before the next frame may start
  logic [7:0] nch_lat;   // latched n_cs high time, never 0
  logic [3:0] frame_k;   // frame currently on the wire
  logic [3:0] sweep_l;   // channels in the running sweep

  logic       len_ok;
  logic [3:0] k_next;
  logic [2:0] gap_ch;
  logic       trig_go;
  logic       gap_go;

  assign len_ok = (sweep_len != 4'd0) && (sweep_len <= N_CH_L);
  assign k_next = frame_k + 4'd1;
  // The last frame only flushes the pipeline, so it re-selects channel 0.
  assign gap_ch = (k_next < sweep_l) ? k_next[2:0] : 3'd0;

  // A frame starts in the very cycle it is granted, so gap_cnt reaching 0
  // at done+nch_lat lines up with the n_cs high time exactly.
  assign trig_go = (state == S_READY) && (gap_cnt == 8'd0) && trig && len_ok &&
                   enable && !tcalc_lock_viol;
  assign gap_go  = (state == S_GAP) && (gap_cnt == 8'd0) && enable && !tcalc_lock_viol;

  assign xfer_start  = trig_go || gap_go;
  assign xfer_cmd    = trig_go ? {OTF_CMD_PREFIX, 3'd0} :
                       gap_go  ? {OTF_CMD_PREFIX, gap_ch} : 16'd0;
  assign ready       = (state == S_READY) && (gap_cnt == 8'd0);
  assign tcalc_start = (state == S_CALC) || (state == S_READY) ||
                       (state == S_XFER) || (state == S_GAP);

  // Sequencer state, gap timing and registered sample/status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      gap_cnt      <= 8'd0;
      nch_lat      <= 8'd0;
      frame_k      <= 4'd0;
      sweep_l      <= 4'd0;
      bad_cmd      <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= 3'd0;
      sample_data  <= 16'd0;
      sweep_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sweep_done   <= 1'b0;
      bad_cmd      <= 1'b0;
      if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;

      case (state)
        S_IDLE: begin
          err <= 1'b0;
          if (enable) state <= S_CALC;
        end

        S_CALC: begin
          if (tcalc_lock_viol) begin
            err   <= 1'b1;
            state <= S_ERROR;
          end else if (!enable) begin
            state <= S_IDLE;
          end else if (tcalc_done) begin
            nch_lat <= (n_cs_high_time == 8'd0) ? 8'd1 : n_cs_high_time;
            state   <= S_READY;
          end
        end

        S_READY: begin
          if (tcalc_lock_viol) begin
            err   <= 1'b1;
            state <= S_ERROR;
          end else if (!enable) begin
            state <= S_IDLE;
          end else if (trig && (gap_cnt == 8'd0)) begin
            if (len_ok) begin
              sweep_l <= sweep_len;
              frame_k <= 4'd0;
              state   <= S_XFER;
            end else begin
              bad_cmd <= 1'b1;
            end
          end
        end

        S_XFER: begin
          if (tcalc_lock_viol) begin
            err <= 1'b1;
            if (xfer_done) begin
              gap_cnt <= nch_lat - 8'd1;
              state   <= S_ERROR;
            end else begin
              state <= S_DRAIN;
            end
          end else if (xfer_done) begin
            gap_cnt <= nch_lat - 8'd1;
            // Frame 0 returns a stale conversion; frame k returns channel k-1.
            if (frame_k != 4'd0) begin
              sample_valid <= 1'b1;
              sample_ch    <= frame_k[2:0] - 3'd1;
              sample_data  <= xfer_data;
            end
            if (!enable) begin
              state <= S_IDLE;
            end else if (frame_k == sweep_l) begin
              sweep_done <= 1'b1;
              state      <= S_READY;
            end else begin
              state <= S_GAP;
            end
          end else if (!enable) begin
            state <= S_DRAIN;
          end
        end

        S_GAP: begin
          if (tcalc_lock_viol) begin
            err   <= 1'b1;
            state <= S_ERROR;
          end else if (!enable) begin
            state <= S_IDLE;
          end else if (gap_cnt == 8'd0) begin
            frame_k <= k_next;
            state   <= S_XFER;
          end
        end

        S_DRAIN: begin
          if (tcalc_lock_viol) err <= 1'b1;
          if (xfer_done) begin
            gap_cnt <= nch_lat - 8'd1;
            state   <= (err || tcalc_lock_viol) ? S_ERROR : S_IDLE;
          end
        end

        S_ERROR: begin
          err <= 1'b1;
          if (!enable) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shim_ads816x_adc_sequencer.sv
// tb/tb_shim_ads816x_adc_sequencer.sv - randomized self-checking bench for shim_ads816x_adc_sequencer
module tb_shim_ads816x_adc_sequencer;

  localparam logic [12:0] PFX = 13'b1010_0000_0000_0;

  logic        clk = 1'b0;
  logic        resetn, enable, tcalc_done, tcalc_lock_viol, trig, xfer_done;
  logic [7:0]  n_cs_high_time;
  logic [3:0]  sweep_len;
  logic [15:0] xfer_data;
  logic        tcalc_start, ready, bad_cmd, xfer_start, sample_valid, sweep_done, err;
  logic [15:0] xfer_cmd, sample_data;
  logic [2:0]  sample_ch;

  shim_ads816x_adc_sequencer dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .tcalc_start(tcalc_start), .tcalc_done(tcalc_done), .tcalc_lock_viol(tcalc_lock_viol),
    .n_cs_high_time(n_cs_high_time), .trig(trig), .sweep_len(sweep_len),
    .ready(ready), .bad_cmd(bad_cmd), .xfer_start(xfer_start), .xfer_cmd(xfer_cmd),
    .xfer_done(xfer_done), .xfer_data(xfer_data), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .sweep_done(sweep_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pend_done = -1;
  int lat_min = 1;
  int lat_max = 6;

  int          st_cyc[$];
  logic [15:0] st_cmd[$];
  int          dn_cyc[$];
  logic [15:0] dn_data[$];
  int          sm_cyc[$];
  logic [2:0]  sm_ch[$];
  logic [15:0] sm_data[$];
  int          sd_cyc[$];
  int          bc_cyc[$];

  task automatic clear_log();
    st_cyc.delete(); st_cmd.delete(); dn_cyc.delete(); dn_data.delete();
    sm_cyc.delete(); sm_ch.delete(); sm_data.delete(); sd_cyc.delete(); bc_cyc.delete();
  endtask

  // One clock cycle: log DUT outputs mid-cycle, then emulate the SPI engine for the next cycle.
  task automatic step();
    @(negedge clk);
    if (xfer_start === 1'b1) begin
      st_cyc.push_back(cyc); st_cmd.push_back(xfer_cmd);
      pend_done = cyc + int'($urandom_range(lat_max, lat_min));
    end
    if (xfer_done)             begin dn_cyc.push_back(cyc); dn_data.push_back(xfer_data); end
    if (sample_valid === 1'b1) begin sm_cyc.push_back(cyc); sm_ch.push_back(sample_ch); sm_data.push_back(sample_data); end
    if (sweep_done === 1'b1)   sd_cyc.push_back(cyc);
    if (bad_cmd === 1'b1)      bc_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    trig = 1'b0; tcalc_done = 1'b0; tcalc_lock_viol = 1'b0;
    xfer_done = (cyc == pend_done);
    xfer_data = xfer_done ? 16'($urandom) : 16'h0000;
    if (xfer_done) pend_done = -1;
  endtask

  task automatic wait_ready(input int budget);
    int b;
    b = 0;
    while (ready !== 1'b1 && b < budget) begin step(); b++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL wait_ready got %b want 1 after %0d cycles", ready, budget); end
  endtask

  task automatic configure(input int nch, input int delay);
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    step();
    repeat (delay) step();
    checks++;
    if (tcalc_start !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL cfg_calc tcalc_start=%b ready=%b want 1/0", tcalc_start, ready);
    end
    n_cs_high_time = 8'(nch);
    tcalc_done = 1'b1;
    step();
    n_cs_high_time = 8'($urandom);
    wait_ready(300);
  endtask

  // Trigger a sweep now and check frames, commands, gaps and samples against the OTF rules.
  task automatic run_sweep(input int len, input int gap, output int last_done);
    int t0, b, n;
    logic [15:0] exp_cmd;
    clear_log();
    last_done = cyc;
    sweep_len = 4'(len); trig = 1'b1; t0 = cyc; b = 0;
    while (sd_cyc.size() == 0 && b < 3000) begin step(); b++; end
    checks++;
    if (sd_cyc.size() != 1) begin errors++; $display("FAIL sweep_done_count L=%0d got %0d want 1", len, sd_cyc.size()); end
    checks++;
    if (st_cyc.size() != len + 1) begin errors++; $display("FAIL frame_count L=%0d got %0d want %0d", len, st_cyc.size(), len + 1); end
    n = (st_cyc.size() < len + 1) ? st_cyc.size() : len + 1;
    for (int i = 0; i < n; i++) begin
      exp_cmd = {PFX, 3'((i < len) ? i : 0)};
      checks++;
      if (st_cmd[i] !== exp_cmd) begin errors++; $display("FAIL cmd[%0d] got %h want %h", i, st_cmd[i], exp_cmd); end
      if (i == 0) begin
        checks++;
        if (st_cyc[0] != t0) begin errors++; $display("FAIL first_start got %0d want %0d", st_cyc[0], t0); end
      end else if (i - 1 < dn_cyc.size()) begin
        checks++;
        if (st_cyc[i] != dn_cyc[i-1] + gap) begin
          errors++; $display("FAIL gap[%0d] start %0d want %0d", i, st_cyc[i], dn_cyc[i-1] + gap);
        end
      end
    end
    checks++;
    if (sm_cyc.size() != len) begin errors++; $display("FAIL sample_count got %0d want %0d", sm_cyc.size(), len); end
    for (int j = 0; j < len && j < sm_cyc.size() && j + 1 < dn_cyc.size(); j++) begin
      checks++;
      if (sm_ch[j] !== 3'(j) || sm_data[j] !== dn_data[j+1] || sm_cyc[j] != dn_cyc[j+1] + 1) begin
        errors++;
        $display("FAIL sample[%0d] ch=%0d data=%h cyc=%0d want ch=%0d data=%h cyc=%0d",
                 j, sm_ch[j], sm_data[j], sm_cyc[j], j, dn_data[j+1], dn_cyc[j+1] + 1);
      end
    end
    if (sd_cyc.size() > 0 && sm_cyc.size() >= len) begin
      checks++;
      if (sd_cyc[0] != sm_cyc[len-1]) begin errors++; $display("FAIL sweep_done_cyc got %0d want %0d", sd_cyc[0], sm_cyc[len-1]); end
    end
    if (dn_cyc.size() > len) last_done = dn_cyc[len];
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; tcalc_done = 1'b0; tcalc_lock_viol = 1'b0; trig = 1'b0;
    xfer_done = 1'b0; xfer_data = 16'h0; n_cs_high_time = 8'h0; sweep_len = 4'h0;
    repeat (3) step();
    checks++;
    if ({xfer_start, ready, err, tcalc_start, sample_valid, sweep_done, bad_cmd} !== 7'b0 ||
        xfer_cmd !== 16'h0 || sample_data !== 16'h0 || sample_ch !== 3'h0) begin
      errors++;
      $display("FAIL reset_outputs start=%b ready=%b err=%b tcs=%b sv=%b sd=%b bc=%b cmd=%h data=%h ch=%0d want all 0",
               xfer_start, ready, err, tcalc_start, sample_valid, sweep_done, bad_cmd, xfer_cmd, sample_data, sample_ch);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int ld;
    configure(5, 69);
    run_sweep(3, 5, ld);
  endtask

  task automatic test_bad_cmd();
    int t0;
    logic [3:0] bad_vals[3];
    bad_vals[0] = 4'd0; bad_vals[1] = 4'd9; bad_vals[2] = 4'($urandom_range(15, 10));
    wait_ready(100);
    for (int i = 0; i < 3; i++) begin
      clear_log();
      sweep_len = bad_vals[i]; trig = 1'b1; t0 = cyc;
      step(); step();
      checks++;
      if (bc_cyc.size() != 1 || (bc_cyc.size() == 1 && bc_cyc[0] != t0 + 1)) begin
        errors++; $display("FAIL bad_cmd len=%0d pulses=%0d want 1 at cycle %0d", bad_vals[i], bc_cyc.size(), t0 + 1);
      end
      checks++;
      if (st_cyc.size() != 0 || ready !== 1'b1) begin
        errors++; $display("FAIL bad_cmd_side len=%0d starts=%0d ready=%b want 0/1", bad_vals[i], st_cyc.size(), ready);
      end
    end
  endtask

  task automatic test_gap_trig();
    int ld, b;
    run_sweep(2, 5, ld);
    while (cyc < ld + 2) step();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL gap_ready_early got %b want 0", ready); end
    clear_log();
    sweep_len = 4'd1; trig = 1'b1;
    while (cyc < ld + 5) step();
    checks++;
    if (st_cyc.size() != 0) begin errors++; $display("FAIL early_trig starts=%0d want 0", st_cyc.size()); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL gap_ready got %b want 1 at done+5", ready); end
    sweep_len = 4'd1; trig = 1'b1;
    step();
    checks++;
    if (st_cyc.size() != 1 || (st_cyc.size() == 1 && st_cyc[0] != ld + 5)) begin
      errors++; $display("FAIL trig_at_gap starts=%0d want 1 at cycle %0d", st_cyc.size(), ld + 5);
    end
    b = 0;
    while (sd_cyc.size() == 0 && b < 200) begin step(); b++; end
    checks++;
    if (sd_cyc.size() != 1) begin errors++; $display("FAIL gap_sweep_done got %0d want 1", sd_cyc.size()); end
  endtask

  task automatic test_nch_zero();
    int ld;
    configure(0, 4);
    run_sweep(4, 1, ld);
    wait_ready(50);
    run_sweep(8, 1, ld);
  endtask

  task automatic test_random_sweeps();
    int nch, gap, len, ld;
    for (int r = 0; r < 4; r++) begin
      nch = int'($urandom_range(12, 1));
      gap = nch;
      configure(nch, int'($urandom_range(10, 1)));
      for (int s = 0; s < 3; s++) begin
        len = int'($urandom_range(8, 1));
        wait_ready(100);
        run_sweep(len, gap, ld);
      end
    end
  endtask

  task automatic test_enable_drop();
    int b;
    configure(3, 5);
    lat_min = 6; lat_max = 6;
    clear_log();
    sweep_len = 4'd4; trig = 1'b1; b = 0;
    while (st_cyc.size() < 3 && b < 200) begin step(); b++; end
    step(); step();
    enable = 1'b0;
    repeat (15) step();
    checks++;
    if (sm_cyc.size() != 1 || sd_cyc.size() != 0) begin
      errors++; $display("FAIL drop_samples samples=%0d sweep_done=%0d want 1/0", sm_cyc.size(), sd_cyc.size());
    end
    checks++;
    if (st_cyc.size() != 3 || dn_cyc.size() != 3) begin
      errors++; $display("FAIL drop_frames starts=%0d dones=%0d want 3/3", st_cyc.size(), dn_cyc.size());
    end
    checks++;
    if (tcalc_start !== 1'b0 || err !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL drop_idle tcs=%b err=%b ready=%b want 0/0/0", tcalc_start, err, ready);
    end
    lat_min = 1; lat_max = 6;
  endtask

  task automatic test_lock_viol_calc();
    enable = 1'b0; repeat (2) step();
    enable = 1'b1; repeat (3) step();
    clear_log();
    tcalc_lock_viol = 1'b1;
    step();
    checks++;
    if (err !== 1'b1 || tcalc_start !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL lock_calc err=%b tcs=%b ready=%b want 1/0/0", err, tcalc_start, ready);
    end
    n_cs_high_time = 8'd5; tcalc_done = 1'b1; sweep_len = 4'd2; trig = 1'b1;
    repeat (5) step();
    checks++;
    if (err !== 1'b1 || st_cyc.size() != 0) begin
      errors++; $display("FAIL lock_hold err=%b starts=%0d want 1/0", err, st_cyc.size());
    end
    enable = 1'b0;
    step();
    checks++;
    if (err !== 1'b0 || tcalc_start !== 1'b0) begin
      errors++; $display("FAIL lock_clear err=%b tcs=%b want 0/0", err, tcalc_start);
    end
    enable = 1'b1;
    step();
    checks++;
    if (tcalc_start !== 1'b1) begin errors++; $display("FAIL reenable tcs=%b want 1", tcalc_start); end
  endtask

  task automatic test_lock_viol_sweep();
    int b;
    configure(4, 3);
    clear_log();
    sweep_len = 4'd5; trig = 1'b1; b = 0;
    while (st_cyc.size() < 2 && b < 200) begin step(); b++; end
    tcalc_lock_viol = 1'b1;
    step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL lock_sweep_err got %b want 1", err); end
    repeat (20) step();
    checks++;
    if (st_cyc.size() != 2 || sd_cyc.size() != 0 || err !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL lock_sweep_abandon starts=%0d sd=%0d err=%b ready=%b want 2/0/1/0",
                         st_cyc.size(), sd_cyc.size(), err, ready);
    end
    enable = 1'b0;
    step();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL lock_sweep_clear err=%b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cmd();
    test_gap_trig();
    test_nch_zero();
    test_random_sweeps();
    test_enable_drop();
    test_lock_viol_calc();
    test_lock_viol_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $fatal(1);
  end

endmodule

// File: doc/shim_ads816x_adc_sequencer.md
Name: shim_ads816x_adc_sequencer

Overview:
Sequences one ADS816x ADC channel through the shim_ads816x_adc_timing_calc block and an external SPI frame engine. On enable it runs the timing calculation and latches the resulting n_cs high time. It then executes channel sweeps in on-the-fly (OTF) mode, enforcing the n_cs gap between frames and tagging each returned sample with its channel. It sits between the system control/trigger logic and the SPI shift engine in the SPI clock domain.

Parameters:
N_CH, 8, number of ADC input channels (max 8; channel index 3 bits)
OTF_CMD_PREFIX, 13'b1010_0000_0000_0, upper 13 bits of the 16-bit OTF channel-select command; channel index in bits [2:0]

Ports:
clk  in  1  SPI-domain clock; all gap counts are in clk cycles
resetn  in  1  reset
enable  in  1  level; high = configure and run, low = shut down
tcalc_start  out  1  drives timing calc "calc"; held high while configured
tcalc_done  in  1  timing calc "done"
tcalc_lock_viol  in  1  timing calc "lock_viol"
n_cs_high_time  in  8  timing calc result
trig  in  1  one-cycle sweep request
sweep_len  in  4  channels per sweep, valid 1..N_CH; sampled with trig
ready  out  1  sweep may be triggered this cycle
bad_cmd  out  1  one-cycle pulse: trig with invalid sweep_len
xfer_start  out  1  one-cycle pulse: SPI engine starts a 16-bit frame (drops n_cs)
xfer_cmd  out  16  MOSI word, valid while xfer_start=1
xfer_done  in  1  one-cycle pulse: frame finished, n_cs raised
xfer_data  in  16  MISO word, valid with xfer_done
sample_valid  out  1  one-cycle pulse
sample_ch  out  3  channel of sample_data
sample_data  out  16  conversion result
sweep_done  out  1  one-cycle pulse after last sample of a sweep
err  out  1  level; timing lock violation, cleared only when enable goes low

Behaviour:
- Reset is synchronous, active-low resetn, on clk. All outputs reset to 0. State resets to S_IDLE. Gap counter, frame counter and latched n_cs time reset to 0.
- States: S_IDLE, S_CALC, S_READY, S_XFER, S_GAP, S_DRAIN, S_ERROR.
- S_IDLE: tcalc_start=0. enable=1 -> S_CALC.
- S_CALC: tcalc_start=1. On tcalc_done=1: latch n_cs_high_time as nch_lat (value 0 treated as 1) -> S_READY. On tcalc_lock_viol -> S_ERROR. On enable=0 -> S_IDLE.
- S_READY: tcalc_start stays 1. ready=1 only when gap counter==0.
  - trig with ready=1 and sweep_len in 1..N_CH: latch L=sweep_len, set frame k=0, assert xfer_start the same cycle with xfer_cmd={OTF_CMD_PREFIX,3'd0} -> S_XFER.
  - trig with invalid sweep_len (0 or >N_CH): bad_cmd pulse the next cycle; state unchanged.
  - trig with gap counter != 0: ignored silently.
- OTF pipeline: frame k carries the command selecting channel k for conversion. The sweep is L+1 frames (k=0..L). Frame k=L sends the channel-0 command, and its conversion is discarded.
- S_XFER: wait for xfer_done.
  - For k>=1: the cycle after xfer_done, sample_valid=1, sample_ch=k-1, sample_data=xfer_data (registered). Frame 0 data is discarded.
  - Load gap counter with nch_lat. If k==L: sweep_done pulses together with the last sample_valid -> S_READY. Else -> S_GAP.
- Gap counter decrements by 1 per cycle to 0 in all states.
- S_GAP: when the counter reaches 0, assert xfer_start for frame k+1 with xfer_cmd={OTF_CMD_PREFIX, ch}, where ch=(k+1) if k+1<L else 0 -> S_XFER.
- Gap timing: if xfer_done is at cycle t, the next xfer_start (within a sweep, or the earliest accepted trig) is at cycle t+nch_lat exactly.
- tcalc_lock_viol in S_READY -> S_ERROR. In S_XFER or S_GAP: set err immediately, abandon the sweep (no further frames), wait out any in-flight frame in S_DRAIN, then -> S_ERROR.
- enable=0 in S_XFER: -> S_DRAIN; in-flight xfer_done is consumed with no sample_valid or sweep_done; then -> S_IDLE. enable=0 in S_GAP or S_READY: -> S_IDLE immediately; xfer_start is never issued once enable is low.
- S_ERROR: err=1, tcalc_start=0, ready=0. enable=0 -> S_IDLE and err clears.
- Timing calc re-run: any entry to S_CALC re-latches nch_lat.
- Simultaneous events: tcalc_lock_viol and trig in the same cycle -> lock_viol wins (no frame started). xfer_done and enable falling in the same cycle -> the sample is still delivered, sweep_done suppressed, -> S_IDLE.

Test Plan:
- Enable, tcalc_done after 70 cycles with n_cs_high_time=5, trig sweep_len=3 -> 4 xfer_start, cmds ch 0,1,2,0; samples ch 0,1,2 carry the frame 1..3 data; each start exactly 5 cycles after prior done; sweep_done with the ch2 sample.
- trig sweep_len=0 and sweep_len=9 in S_READY -> bad_cmd pulse each; no xfer_start; ready stays 1.
- trig 2 cycles after sweep_done with n_cs_high_time=5 -> ignored; trig at done+5 -> accepted.
- tcalc_lock_viol during S_CALC -> err=1, tcalc_start=0, no frames; enable low -> err=0, S_IDLE; re-enable -> tcalc_start=1.
- enable low mid-frame (sweep_len=4, during frame 2) -> the in-flight xfer_done produces no sample_valid; no further xfer_start; tcalc_start=0.
- n_cs_high_time=0 -> gap of exactly 1 cycle between done and next start.
